bcd_countdown_timer: RTL and testbench
======================================

// Module: bcd_countdown_timer
// PURPOSE
//  Microwave cook-time source: accepts keypad digits, holds time as three BCD digits
//  (M:ST:SO, max 9:59) and counts down once per second while running.
//  Drives the sec_ones/sec_tens/mins inputs of the 7-segment decoder.
//  Reports running/paused state and a one-cycle done pulse at 0:00 to the controller FSM.
// PARAMETERS
//  TICKS_PER_SEC  50_000_000  clock cycles per 1 s decrement; prescaler width = $clog2(TICKS_PER_SEC)
// PORTS
//  clock        in   1  system clock; all state updates on rising edge
//  reset        in   1  asynchronous, active-high reset
//  digit_in     in   4  keypad digit, BCD 0-9
//  digit_valid  in   1  1-cycle strobe qualifying digit_in
//  start        in   1  1-cycle strobe: start/resume cooking
//  stop         in   1  1-cycle strobe: pause, or clear when not running
//  door_open    in   1  level; high forces pause and blocks start
//  sec_ones     out  4  BCD seconds ones, 0-9
//  sec_tens     out  4  BCD seconds tens, 0-5
//  mins         out  4  BCD minutes, 0-9
//  running      out  1  high in RUN
//  paused       out  1  high in PAUSE
//  done         out  1  1-cycle pulse when countdown reaches 0:00
// BEHAVIOUR
//  - Reset (async): digits 0:00, prescaler 0, state SET, running/paused/done 0.
//  - States: SET, RUN, PAUSE. All outputs registered; done low except its pulse cycle.
//  - Priority per cycle: door_open > stop > start > digit_valid.
//  - SET, digit_valid and digit_in<=9 and sec_ones<=5: shift left:
//    mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=digit_in; old mins discarded.
//    digit_in>9 or sec_ones>5 (tens would exceed 5): entry ignored, no change.
//  - digit_valid outside SET: ignored.
//  - SET, start, door closed, time!=0:00 -> RUN, prescaler cleared to 0. Time 0:00: stay SET.
//  - SET, stop -> digits cleared to 0:00, stay SET.
//  - RUN: prescaler increments each cycle; at TICKS_PER_SEC-1 it wraps to 0 and time
//    decrements on that same edge. First decrement TICKS_PER_SEC cycles after start edge.
//  - Decrement: SO>0: SO-1. SO=0,ST>0: SO=9,ST-1. SO=0,ST=0: SO=9,ST=5,M-1.
//  - Decrement reaching 0:00: same edge state->SET, done=1 for exactly one cycle.
//  - RUN, stop or door_open -> PAUSE; prescaler holds its value, digits hold.
//  - PAUSE, start with door closed -> RUN; prescaler resumes from held value.
//  - PAUSE, stop (door closed) -> digits 0:00, prescaler 0, SET.
//  - start while door_open: ignored in every state.
//  - start and stop in same cycle: stop action only.
//  - Reset mid-RUN: immediate 0:00/SET, no done pulse.
//  - 0:00 never decremented; no underflow possible.
// TESTING (bench overrides TICKS_PER_SEC=4)
//  1 Assert reset mid-sim -> outputs 0/0/0, running=0, paused=0, done=0 asynchronously.
//  2 Keys 1,3,0 -> 1:30; then 9 -> 3:09; then 7 -> ignored, stays 3:09; key 12 -> ignored.
//  3 Load 1:00, start -> running=1; 4 cycles later 0:59; 40 cycles after start 0:50.
//  4 Load 0:02, start -> 0:01 at cycle 4, 0:00 + done=1 at cycle 8 for one cycle,
//    running=0.
//  5 Load 0:05, start, door_open at cycle 2 -> paused=1, digits hold;
//    start while open ignored; close, start -> next decrement 2 cycles later.
//  6 RUN with start+stop same cycle -> PAUSE;
//    stop again -> 0:00 SET; start at 0:00 -> stays SET.

Source files
------------

// File: rtl/bcd_countdown_timer.sv
// Microwave cook-time counter: keypad entry into three BCD digits (M:ST:SO),
// once-per-second countdown while running, with pause/resume and a done pulse.
module bcd_countdown_timer #(
    parameter int TICKS_PER_SEC = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] digit_in,
    input  logic       digit_valid,
    input  logic       start,
    input  logic       stop,
    input  logic       door_open,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic       running,
    output logic       paused,
    output logic       done
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        ST_SET   = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    so_q, so_d;
    logic [3:0]    st_q, st_d;
    logic [3:0]    m_q, m_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          done_q, done_d;
    logic          running_q, running_d;
    logic          paused_q, paused_d;

    logic          time_zero;
    logic          digit_ok;
    logic [11:0]   dec_time;

    // One-second BCD decrement with borrow across seconds-ones, seconds-tens, minutes.
    function automatic logic [11:0] bcd_dec(input logic [3:0] m, input logic [3:0] st,
                                            input logic [3:0] so);
        logic [11:0] r;
        if (so != 4'd0)
            r = {m, st, so - 4'd1};
        else if (st != 4'd0)
            r = {m, st - 4'd1, 4'd9};
        else
            r = {m - 4'd1, 4'd5, 4'd9};
        return r;
    endfunction

    assign time_zero = (m_q == 4'd0) && (st_q == 4'd0) && (so_q == 4'd0);
    // The current ones digit becomes the tens digit, so it must be a legal tens value.
    assign digit_ok  = (digit_in <= 4'd9) && (so_q <= 4'd5);
    assign dec_time  = bcd_dec(m_q, st_q, so_q);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_SET;
            so_q      <= 4'd0;
            st_q      <= 4'd0;
            m_q       <= 4'd0;
            pre_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            so_q      <= so_d;
            st_q      <= st_d;
            m_q       <= m_d;
            pre_q     <= pre_d;
            done_q    <= done_d;
            running_q <= running_d;
            paused_q  <= paused_d;
        end
    end

    always_comb begin
        state_d = state_q;
        so_d    = so_q;
        st_d    = st_q;
        m_d     = m_q;
        pre_d   = pre_q;
        done_d  = 1'b0;

        case (state_q)
            ST_SET: begin
                if (!door_open) begin
                    if (stop) begin
                        so_d = 4'd0;
                        st_d = 4'd0;
                        m_d  = 4'd0;
                    end else if (start) begin
                        if (!time_zero) begin
                            state_d = ST_RUN;
                            pre_d   = '0;
                        end
                    end else if (digit_valid && digit_ok) begin
                        m_d  = st_q;
                        st_d = so_q;
                        so_d = digit_in;
                    end
                end
            end
            ST_RUN: begin
                if (door_open || stop) begin
                    state_d = ST_PAUSE;
                end else if (pre_q == PRE_MAX) begin
                    pre_d = '0;
                    {m_d, st_d, so_d} = dec_time;
                    if (dec_time == 12'd0) begin
                        state_d = ST_SET;
                        done_d  = 1'b1;
                    end
                end else begin
                    pre_d = pre_q + PW'(1);
                end
            end
            ST_PAUSE: begin
                if (!door_open) begin
                    if (stop) begin
                        so_d    = 4'd0;
                        st_d    = 4'd0;
                        m_d     = 4'd0;
                        pre_d   = '0;
                        state_d = ST_SET;
                    end else if (start) begin
                        state_d = ST_RUN;
                    end
                end
            end
            default: state_d = ST_SET;
        endcase

        running_d = (state_d == ST_RUN);
        paused_d  = (state_d == ST_PAUSE);
    end

    assign sec_ones = so_q;
    assign sec_tens = st_q;
    assign mins     = m_q;
    assign running  = running_q;
    assign paused   = paused_q;
    assign done     = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a seconds-based reference model.
module tb_bcd_countdown_timer;

    localparam int T = 4;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] digit_in = 4'd0;
    logic       digit_valid = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       door_open = 1'b0;
    logic [3:0] sec_ones, sec_tens, mins;
    logic       running, paused, done;

    int n_checks = 0;
    int n_fail   = 0;

    bcd_countdown_timer #(.TICKS_PER_SEC(T)) dut (
        .clock(clock), .reset(reset), .digit_in(digit_in), .digit_valid(digit_valid),
        .start(start), .stop(stop), .door_open(door_open),
        .sec_ones(sec_ones), .sec_tens(sec_tens), .mins(mins),
        .running(running), .paused(paused), .done(done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: time held as total seconds; state 0=SET 1=RUN 2=PAUSE.
    int   ms    = 0;
    int   mst   = 0;
    int   mpre  = 0;
    logic mdone = 1'b0;

    initial begin
        forever begin
            @(posedge clock or posedge reset);
            if (reset) begin
                ms = 0; mst = 0; mpre = 0; mdone = 1'b0;
            end else begin
                mdone = 1'b0;
                case (mst)
                    0: if (!door_open) begin
                        if (stop) ms = 0;
                        else if (start) begin
                            if (ms != 0) begin mst = 1; mpre = 0; end
                        end else if (digit_valid && digit_in <= 9 && (ms % 10) <= 5)
                            ms = ((ms % 60) / 10) * 60 + (ms % 10) * 10 + int'(digit_in);
                    end
                    1: if (door_open || stop) mst = 2;
                       else begin
                           mpre++;
                           if (mpre == T) begin
                               mpre = 0;
                               ms--;
                               if (ms == 0) begin mst = 0; mdone = 1'b1; end
                           end
                       end
                    default: if (!door_open) begin
                        if (stop) begin ms = 0; mpre = 0; mst = 0; end
                        else if (start) mst = 1;
                    end
                endcase
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock);
            chk("m_sec_ones", 32'(sec_ones), 32'(ms % 10));
            chk("m_sec_tens", 32'(sec_tens), 32'((ms % 60) / 10));
            chk("m_mins",     32'(mins),     32'(ms / 60));
            chk("m_running",  32'(running),  32'(mst == 1));
            chk("m_paused",   32'(paused),   32'(mst == 2));
            chk("m_done",     32'(done),     32'(mdone));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic key(input logic [3:0] d);
        digit_in = d; digit_valid = 1'b1;
        tick(1);
        digit_valid = 1'b0;
    endtask

    task automatic press_start();
        start = 1'b1; tick(1); start = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1; tick(1); stop = 1'b0;
    endtask

    task automatic chk_time(input string name, input int m, input int st, input int so);
        chk({name, "_m"},  32'(mins),     32'(m));
        chk({name, "_st"}, 32'(sec_tens), 32'(st));
        chk({name, "_so"}, 32'(sec_ones), 32'(so));
    endtask

    initial begin
        tick(2);
        reset = 1'b0;
        tick(1);
        chk_time("rst", 0, 0, 0);
        chk("rst_running", 32'(running), 0);

        // Keypad entry and rejected keys
        key(4'd1); key(4'd3); key(4'd0);
        chk_time("key130", 1, 3, 0);
        key(4'd9);
        chk_time("key309", 3, 0, 9);
        key(4'd7);
        chk_time("key_tens_over", 3, 0, 9);
        press_stop();
        chk_time("stop_clear", 0, 0, 0);
        key(4'd12);
        chk_time("key_12", 0, 0, 0);

        // Countdown from 1:00
        key(4'd1); key(4'd0); key(4'd0);
        press_start();
        chk("run_started", 32'(running), 1);
        tick(4);
        chk_time("run_0_59", 0, 5, 9);
        tick(36);
        chk_time("run_0_50", 0, 5, 0);
        press_stop();
        press_stop();

        // Countdown to zero with done pulse
        key(4'd2);
        press_start();
        tick(4);
        chk_time("z_0_01", 0, 0, 1);
        tick(4);
        chk_time("z_0_00", 0, 0, 0);
        chk("z_done", 32'(done), 1);
        chk("z_running", 32'(running), 0);
        tick(1);
        chk("z_done_pulse", 32'(done), 0);

        // Door interrupts, start blocked while open, resume from held prescaler
        key(4'd5);
        press_start();
        tick(2);
        door_open = 1'b1;
        tick(1);
        chk("door_paused", 32'(paused), 1);
        chk_time("door_hold", 0, 0, 5);
        press_start();
        chk("door_start_blocked", 32'(paused), 1);
        door_open = 1'b0;
        press_start();
        chk("resume_running", 32'(running), 1);
        tick(1);
        chk_time("resume_hold", 0, 0, 5);
        tick(1);
        chk_time("resume_dec", 0, 0, 4);

        // start+stop together pauses; stop clears; start at 0:00 stays in SET
        start = 1'b1; stop = 1'b1; tick(1); start = 1'b0; stop = 1'b0;
        chk("both_paused", 32'(paused), 1);
        press_stop();
        chk_time("pause_clear", 0, 0, 0);
        chk("pause_clear_paused", 32'(paused), 0);
        press_start();
        chk("zero_start_running", 32'(running), 0);

        // Asynchronous reset mid-run
        key(4'd5);
        press_start();
        tick(2);
        chk("pre_reset_running", 32'(running), 1);
        #2 reset = 1'b1;
        #1;
        chk_time("async_rst", 0, 0, 0);
        chk("async_rst_running", 32'(running), 0);
        chk("async_rst_done", 32'(done), 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            digit_in    = 4'($urandom_range(0, 11));
            digit_valid = ($urandom_range(0, 99) < 40);
            start       = ($urandom_range(0, 99) < 8);
            stop        = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 99) < 3) door_open = ~door_open;
            reset       = ($urandom_range(0, 999) < 3);
            tick(1);
        end
        digit_valid = 1'b0; start = 1'b0; stop = 1'b0; door_open = 1'b0; reset = 1'b0;
        tick(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
